pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central hazard/flow controller for the 5-stage MIPS pipeline; produces the go (enable) and
//  clear (bubble) pairs consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB buffers. Resolves
//  load-use stalls, taken-branch flushes, data-memory wait states and syscall halt/resume.
//  Outputs are combinational from state + inputs; buffers sample them at the same posedge clk.
// PARAMETERS
//  CNT_W  32  width of statistics counters (STATS_EN only)
// PORTS
//  clk            in   1      pipeline clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  load_use       in   1      ID reads a reg written by a load currently in EX
//  branch_taken   in   1      branch/jump resolved taken in EX this cycle
//  dmem_busy      in   1      data memory not ready; MEM must hold
//  syscall_wb     in   1      syscall instruction is in WB (MEM_WB syscall_out)
//  halt_req       in   1      syscall in WB is the halt service ($v0==10); valid with syscall_wb
//  resume         in   1      level input (button); rising edge leaves HALT
//  go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb              out 1 each  buffer enables
//  clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb         out 1 each  load zero bubble
//  halted         out  1      1 while in HALT
//  cycle_cnt, stall_cnt, flush_cnt  out CNT_W  statistics (zero without STATS_EN)
// BEHAVIOUR
//  - States: RUN, HALT. Reset (rst_n=0): state=RUN, resume_q=0, counters=0; while rst_n=0 all
//    go=0, all clear=1, halted=0.
//  - Priority in RUN (highest first): halt-entry > dmem_busy > branch_taken > load_use > normal.
//  - normal: all go=1, all clear=0.
//  - load_use: go_pc=0, go_if_id=0, clear_id_ex=1; rest go=1. One-cycle stall per assertion.
//  - branch_taken: all go=1, clear_if_id=1, clear_id_ex=1 (two wrong-path slots flushed);
//    a simultaneous load_use is ignored (it belongs to a flushed instruction).
//  - dmem_busy: go_pc..go_ex_mem=0, go_mem_wb=1 with clear_mem_wb=1 (no double WB, no repeated
//    syscall). Branch/load_use pending during busy are re-evaluated after busy drops.
//  - halt-entry (syscall_wb & halt_req in RUN): halting syscall completes WB this cycle;
//    go_pc..go_ex_mem=0, go_mem_wb=1, clear_mem_wb=1; state->HALT at next edge.
//    syscall_wb without halt_req: no action (normal flow).
//  - HALT: same outputs as halt-entry every cycle, halted=1. resume_q<=resume each cycle;
//    resume & ~resume_q -> RUN next edge (first RUN cycle is normal). Resume held high through
//    halt entry does not resume; needs a fresh low->high.
//  - rst_n asserted mid-operation: immediate return to RUN-reset values, no edge required.
// CONFIGURATION
//  PIPELINE_CTRL_STATS_EN defined: cycle_cnt +1 each RUN cycle; stall_cnt +1 each RUN cycle
//  with load_use or dmem_busy winning; flush_cnt +1 each cycle branch_taken wins. All saturate
//  at 2^CNT_W-1, hold in HALT. Not defined: counters absent, outputs tied to 0.
// STRUCTURE
//  - pipeline_ctrl_pkg: state encoding (RUN=0, HALT=1), go/clear vector bit indices per stage.
//  - Sub-module rise_detect (resume_q register + edge pulse, async active-low reset).
//  - One registered state, one combinational priority block driving go/clear vectors.
// TESTING
//  1. Idle RUN, no inputs -> all go=1, all clear=0 every cycle; cycle_cnt=N after N cycles.
//  2. load_use=1 for 1 cycle -> go_pc=go_if_id=0, clear_id_ex=1 that cycle; stall_cnt=1.
//  3. branch_taken=1 with load_use=1 -> clear_if_id=clear_id_ex=1, go_pc=1; flush_cnt=1,
//     stall_cnt=0.
//  4. dmem_busy=1 for 3 cycles with branch_taken=1 -> 3 freeze cycles (clear_mem_wb=1), then
//     flush cycle; stall_cnt=3, flush_cnt=1.
//  5. syscall_wb=halt_req=1, resume held 1 -> halted=1 next cycle, stays; resume 0->1 ->
//     halted=0 one cycle later, cycle_cnt frozen during HALT.
//  6. rst_n pulsed low while in HALT -> halted=0 asynchronously, all clear=1 during reset,
//     counters 0, normal RUN after release.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/flow controller: FSM state, winning hazard action,
// and the bit positions of the per-stage go/clear vectors.
package pipeline_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Which rule wins the priority decision in the current cycle.
  typedef enum logic [2:0] {
    ACT_NORMAL,
    ACT_LOAD_USE,
    ACT_BRANCH,
    ACT_DMEM,
    ACT_HALT
  } action_e;

  localparam int GO_W       = 5;
  localparam int GO_PC      = 0;
  localparam int GO_IF_ID   = 1;
  localparam int GO_ID_EX   = 2;
  localparam int GO_EX_MEM  = 3;
  localparam int GO_MEM_WB  = 4;

  localparam int CLR_W      = 4;
  localparam int CLR_IF_ID  = 0;
  localparam int CLR_ID_EX  = 1;
  localparam int CLR_EX_MEM = 2;
  localparam int CLR_MEM_WB = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and go/clear/status outputs of the pipeline controller.
// master = controller side, slave = pipeline datapath side.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             load_use;
  logic             branch_taken;
  logic             dmem_busy;
  logic             syscall_wb;
  logic             halt_req;
  logic             resume;

  logic             go_pc;
  logic             go_if_id;
  logic             go_id_ex;
  logic             go_ex_mem;
  logic             go_mem_wb;
  logic             clear_if_id;
  logic             clear_id_ex;
  logic             clear_ex_mem;
  logic             clear_mem_wb;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  load_use, branch_taken, dmem_busy, syscall_wb, halt_req, resume,
    output go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
    output clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb,
    output halted, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    output load_use, branch_taken, dmem_busy, syscall_wb, halt_req, resume,
    input  go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
    input  clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb,
    input  halted, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_rise_detect.sv
// Registers a level input and emits a one-cycle-wide pulse on its low->high transition.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);
  logic level_q;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flow controller for the 5-stage pipeline: stalls, flushes, memory waits, syscall halt.
// Define PIPELINE_CTRL_STATS_EN to build the cycle/stall/flush statistics counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.master bus
);
  state_e             state_q, state_d;
  action_e            act;
  logic               resume_rise;
  logic [GO_W-1:0]    go_vec;
  logic [CLR_W-1:0]   clr_vec;

  rise_detect u_resume (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (bus.resume),
    .pulse_o (resume_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    act     = ACT_NORMAL;
    state_d = state_q;
    if (state_q == ST_HALT) begin
      act = ACT_HALT;
      if (resume_rise) state_d = ST_RUN;
    end else if (bus.syscall_wb && bus.halt_req) begin
      act     = ACT_HALT;
      state_d = ST_HALT;
    end else if (bus.dmem_busy) begin
      act = ACT_DMEM;
    end else if (bus.branch_taken) begin
      act = ACT_BRANCH;
    end else if (bus.load_use) begin
      act = ACT_LOAD_USE;
    end
  end

  // Freeze and halt both let MEM_WB retire once and then refill it with a bubble.
  always_comb begin
    go_vec  = '1;
    clr_vec = '0;
    unique case (act)
      ACT_LOAD_USE: begin
        go_vec[GO_PC]        = 1'b0;
        go_vec[GO_IF_ID]     = 1'b0;
        clr_vec[CLR_ID_EX]   = 1'b1;
      end
      ACT_BRANCH: begin
        clr_vec[CLR_IF_ID]   = 1'b1;
        clr_vec[CLR_ID_EX]   = 1'b1;
      end
      ACT_DMEM, ACT_HALT: begin
        go_vec               = '0;
        go_vec[GO_MEM_WB]    = 1'b1;
        clr_vec[CLR_MEM_WB]  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      go_vec  = '0;
      clr_vec = '1;
    end
  end

  assign bus.go_pc        = go_vec[GO_PC];
  assign bus.go_if_id     = go_vec[GO_IF_ID];
  assign bus.go_id_ex     = go_vec[GO_ID_EX];
  assign bus.go_ex_mem    = go_vec[GO_EX_MEM];
  assign bus.go_mem_wb    = go_vec[GO_MEM_WB];
  assign bus.clear_if_id  = clr_vec[CLR_IF_ID];
  assign bus.clear_id_ex  = clr_vec[CLR_ID_EX];
  assign bus.clear_ex_mem = clr_vec[CLR_EX_MEM];
  assign bus.clear_mem_wb = clr_vec[CLR_MEM_WB];
  assign bus.halted       = (state_q == ST_HALT);

`ifdef PIPELINE_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (cycle_q != CNT_MAX) cycle_q <= cycle_q + CNT_W'(1);
      if ((act == ACT_LOAD_USE || act == ACT_DMEM) && stall_q != CNT_MAX)
        stall_q <= stall_q + CNT_W'(1);
      if (act == ACT_BRANCH && flush_q != CNT_MAX)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.cycle_cnt = {CNT_W{1'b0}};
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus random traffic,
// compared against a cycle-level model of the controller's rules.
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_halted;
  bit          m_prev_resume;
  int unsigned m_cyc, m_stall, m_flush;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int unsigned v);
`ifdef PIPELINE_CTRL_STATS_EN
    return 64'(v);
`else
    return 64'(v & 0);
`endif
  endfunction

  function automatic logic [4:0] go_obs();
    return {bus.go_mem_wb, bus.go_ex_mem, bus.go_id_ex, bus.go_if_id, bus.go_pc};
  endfunction

  function automatic logic [3:0] clr_obs();
    return {bus.clear_mem_wb, bus.clear_ex_mem, bus.clear_id_ex, bus.clear_if_id};
  endfunction

  task automatic model_reset();
    m_halted = 0; m_prev_resume = 0;
    m_cyc = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_go"},     64'(go_obs()),  64'h00);
    check({tag, "_clear"},  64'(clr_obs()), 64'hf);
    check({tag, "_halted"}, 64'(bus.halted), 64'h0);
    check({tag, "_cyc"},    64'(bus.cycle_cnt), 64'h0);
    check({tag, "_stall"},  64'(bus.stall_cnt), 64'h0);
    check({tag, "_flush"},  64'(bus.flush_cnt), 64'h0);
  endtask

  // One clock cycle: entered #1 after a posedge; drive, check mid-cycle, advance model at edge.
  task automatic step(input string tag, input bit lu, input bit bt, input bit db,
                      input bit sw, input bit hr, input bit rs);
    logic [4:0] e_go;
    logic [3:0] e_clr;
    bus.load_use = lu; bus.branch_taken = bt; bus.dmem_busy = db;
    bus.syscall_wb = sw; bus.halt_req = hr; bus.resume = rs;
    #3;
    e_go = 5'b11111; e_clr = 4'b0000;
    if (m_halted || (sw && hr) || db) begin
      e_go = 5'b10000; e_clr = 4'b1000;
    end else if (bt) begin
      e_clr = 4'b0011;
    end else if (lu) begin
      e_go = 5'b11100; e_clr = 4'b0010;
    end
    check({tag, "_go"},     64'(go_obs()),  64'(e_go));
    check({tag, "_clear"},  64'(clr_obs()), 64'(e_clr));
    check({tag, "_halted"}, 64'(bus.halted), 64'(m_halted));
    check({tag, "_cyc"},    64'(bus.cycle_cnt), cnt_exp(m_cyc));
    check({tag, "_stall"},  64'(bus.stall_cnt), cnt_exp(m_stall));
    check({tag, "_flush"},  64'(bus.flush_cnt), cnt_exp(m_flush));
    @(posedge clk);
    if (!m_halted) begin
      m_cyc++;
      if (!(sw && hr)) begin
        if (db || (!bt && lu)) m_stall++;
        else if (bt)           m_flush++;
      end
    end
    if (!m_halted && sw && hr)               m_halted = 1;
    else if (m_halted && rs && !m_prev_resume) m_halted = 0;
    m_prev_resume = rs;
    #1;
  endtask

  initial begin
    bus.load_use = 0; bus.branch_taken = 0; bus.dmem_busy = 0;
    bus.syscall_wb = 0; bus.halt_req = 0; bus.resume = 0;
    model_reset();

    #2 check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle RUN
    for (int i = 0; i < 6; i++) step("idle", 0, 0, 0, 0, 0, 0);
    // Single load-use stall
    step("lu", 1, 0, 0, 0, 0, 0);
    step("lu_after", 0, 0, 0, 0, 0, 0);
    // Branch beats simultaneous load-use
    step("br_lu", 1, 1, 0, 0, 0, 0);
    step("br_after", 0, 0, 0, 0, 0, 0);
    // Memory wait holds a pending branch for three cycles
    for (int i = 0; i < 3; i++) step("busy_br", 0, 1, 1, 0, 0, 0);
    step("br_release", 0, 1, 0, 0, 0, 0);
    // Syscall without halt service is ignored
    step("sys_nohalt", 0, 0, 0, 1, 0, 0);
    // Halt with resume held high: no resume until a fresh rising edge
    step("halt_entry", 1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step("halt_held", 0, 1, 1, 0, 0, 1);
    step("halt_low", 0, 0, 0, 0, 0, 0);
    step("halt_rise", 0, 0, 0, 0, 0, 1);
    step("resumed", 0, 0, 0, 0, 0, 1);
    step("run_again", 0, 0, 0, 0, 0, 0);
    // Asynchronous reset while halted
    step("halt2_entry", 0, 0, 0, 1, 1, 0);
    step("halt2", 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit sw;
      sw = ($urandom_range(0, 9) == 0);
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, sw, sw && $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
